// File: rtl/alu_issue_stage_if.sv
// Handshake and forward-bus bundle between decode, the issue stage and the ALU.
// The master modport is the environment side; the slave modport is the issue stage.
interface alu_issue_stage_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [REGW-1:0] in_rs1_idx;
    logic [REGW-1:0] in_rs2_idx;
    logic [REGW-1:0] in_rd_idx;
    logic [XLEN-1:0] in_rs1_val;
    logic [XLEN-1:0] in_rs2_val;
    logic [XLEN-1:0] in_imm;
    logic            in_use_imm;
    logic [2:0]      in_alu_sel;
    logic            flush;
    logic            fwd_ex_we;
    logic [REGW-1:0] fwd_ex_rd;
    logic [XLEN-1:0] fwd_ex_data;
    logic            fwd_mem_we;
    logic [REGW-1:0] fwd_mem_rd;
    logic [XLEN-1:0] fwd_mem_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [2:0]      out_alu_sel;
    logic [REGW-1:0] out_rd_idx;
    logic [CNTW-1:0] stall_cnt;

    modport master (
        output in_valid, in_rs1_idx, in_rs2_idx, in_rd_idx, in_rs1_val, in_rs2_val,
        output in_imm, in_use_imm, in_alu_sel, flush,
        output fwd_ex_we, fwd_ex_rd, fwd_ex_data, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
        output out_ready,
        input  in_ready, out_valid, out_a, out_b, out_alu_sel, out_rd_idx, stall_cnt
    );

    modport slave (
        input  in_valid, in_rs1_idx, in_rs2_idx, in_rd_idx, in_rs1_val, in_rs2_val,
        input  in_imm, in_use_imm, in_alu_sel, flush,
        input  fwd_ex_we, fwd_ex_rd, fwd_ex_data, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
        input  out_ready,
        output in_ready, out_valid, out_a, out_b, out_alu_sel, out_rd_idx, stall_cnt
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Execute-issue stage: forwards EX/MEM results into operands, holds them coherent while stalled.
// Optional feature macro ALU_ISSUE_SHAMT_MASK_EN masks operand B to 5 bits for shift ops.
module alu_issue_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = 16
) (
    input logic              clk,
    input logic              rst,
    alu_issue_stage_if.slave bus
);
`ifdef ALU_ISSUE_SHAMT_MASK_EN
    localparam logic SHAMT_MASK_EN = 1'b1;
`else
    localparam logic SHAMT_MASK_EN = 1'b0;
`endif

    logic            valid_q, valid_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]      sel_q, sel_d;
    logic [REGW-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic            use_imm_q, use_imm_d;
    logic [CNTW-1:0] stall_q, stall_d;

    logic            in_ready_s, accept_s, hold_s;
    logic [XLEN-1:0] cap_a_s, cap_b_s, hold_a_s, hold_b_s;

    // EX result wins over MEM; register 0 is hard-wired and never forwarded.
    function automatic logic [XLEN-1:0] fwd_resolve(
        input logic [REGW-1:0] idx,
        input logic [XLEN-1:0] base,
        input logic            ex_we,
        input logic [REGW-1:0] ex_rd,
        input logic [XLEN-1:0] ex_data,
        input logic            mem_we,
        input logic [REGW-1:0] mem_rd,
        input logic [XLEN-1:0] mem_data
    );
        if ((idx != {REGW{1'b0}}) && ex_we && (ex_rd == idx)) begin
            return ex_data;
        end else if ((idx != {REGW{1'b0}}) && mem_we && (mem_rd == idx)) begin
            return mem_data;
        end else begin
            return base;
        end
    endfunction

    function automatic logic [XLEN-1:0] shamt_mask(input logic [2:0] sel, input logic [XLEN-1:0] val);
        if (SHAMT_MASK_EN && ((sel == 3'b011) || (sel == 3'b100))) begin
            return {{(XLEN-5){1'b0}}, val[4:0]};
        end else begin
            return val;
        end
    endfunction

    assign in_ready_s = !valid_q || bus.out_ready;
    assign accept_s   = bus.in_valid && in_ready_s;
    assign hold_s     = valid_q && !bus.out_ready;

    // Candidate operands for a fresh capture and for re-snooping a held instruction.
    always_comb begin
        cap_a_s  = fwd_resolve(bus.in_rs1_idx, bus.in_rs1_val, bus.fwd_ex_we, bus.fwd_ex_rd,
                               bus.fwd_ex_data, bus.fwd_mem_we, bus.fwd_mem_rd, bus.fwd_mem_data);
        cap_b_s  = shamt_mask(bus.in_alu_sel, bus.in_use_imm ? bus.in_imm :
                   fwd_resolve(bus.in_rs2_idx, bus.in_rs2_val, bus.fwd_ex_we, bus.fwd_ex_rd,
                               bus.fwd_ex_data, bus.fwd_mem_we, bus.fwd_mem_rd, bus.fwd_mem_data));
        hold_a_s = fwd_resolve(rs1_q, a_q, bus.fwd_ex_we, bus.fwd_ex_rd, bus.fwd_ex_data,
                               bus.fwd_mem_we, bus.fwd_mem_rd, bus.fwd_mem_data);
        hold_b_s = use_imm_q ? b_q :
                   shamt_mask(sel_q, fwd_resolve(rs2_q, b_q, bus.fwd_ex_we, bus.fwd_ex_rd,
                              bus.fwd_ex_data, bus.fwd_mem_we, bus.fwd_mem_rd, bus.fwd_mem_data));
    end

    // Next-state selection: flush beats accept, accept beats hold.
    always_comb begin
        valid_d   = valid_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        use_imm_d = use_imm_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept_s) begin
            valid_d   = 1'b1;
            a_d       = cap_a_s;
            b_d       = cap_b_s;
            sel_d     = bus.in_alu_sel;
            rd_d      = bus.in_rd_idx;
            rs1_d     = bus.in_rs1_idx;
            rs2_d     = bus.in_rs2_idx;
            use_imm_d = bus.in_use_imm;
        end else if (hold_s) begin
            a_d = hold_a_s;
            b_d = hold_b_s;
        end else begin
            valid_d = 1'b0;
        end
    end

    // Stall counter saturates rather than wrapping; flush leaves it alone.
    always_comb begin
        if (hold_s && (stall_q != {CNTW{1'b1}})) begin
            stall_d = stall_q + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            stall_d = stall_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            a_q       <= {XLEN{1'b0}};
            b_q       <= {XLEN{1'b0}};
            sel_q     <= 3'b000;
            rd_q      <= {REGW{1'b0}};
            rs1_q     <= {REGW{1'b0}};
            rs2_q     <= {REGW{1'b0}};
            use_imm_q <= 1'b0;
            stall_q   <= {CNTW{1'b0}};
        end else begin
            valid_q   <= valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sel_q     <= sel_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            use_imm_q <= use_imm_d;
            stall_q   <= stall_d;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = valid_q;
    assign bus.out_a       = a_q;
    assign bus.out_b       = b_q;
    assign bus.out_alu_sel = sel_q;
    assign bus.out_rd_idx  = rd_q;
    assign bus.stall_cnt   = stall_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: expected issues go into a scoreboard queue and
// a negedge monitor compares each one as the ALU consumes it.
module tb_alu_issue_stage;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  sel;
        logic [4:0]  rd;
    } exp_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    exp_t sb[$];

`ifdef ALU_ISSUE_SHAMT_MASK_EN
    localparam bit MASK_ON = 1'b1;
`else
    localparam bit MASK_ON = 1'b0;
`endif

    alu_issue_stage_if #(.XLEN(32), .REGW(5), .CNTW(16)) bus ();

    alu_issue_stage #(.XLEN(32), .REGW(5), .CNTW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [31:0] v1, input logic [4:0] rs2,
                         input logic [31:0] v2, input logic [31:0] imm, input logic use_imm,
                         input logic [2:0] sel, input logic [4:0] rd);
        bus.in_valid   = 1'b1;
        bus.in_rs1_idx = rs1;
        bus.in_rs1_val = v1;
        bus.in_rs2_idx = rs2;
        bus.in_rs2_val = v2;
        bus.in_imm     = imm;
        bus.in_use_imm = use_imm;
        bus.in_alu_sel = sel;
        bus.in_rd_idx  = rd;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                        input logic [4:0] rd);
        exp_t e;
        e.a = a; e.b = b; e.sel = sel; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic set_fwd(input logic ex_we, input logic [4:0] ex_rd, input logic [31:0] ex_d,
                           input logic mem_we, input logic [4:0] mem_rd, input logic [31:0] mem_d);
        bus.fwd_ex_we = ex_we;   bus.fwd_ex_rd = ex_rd;   bus.fwd_ex_data = ex_d;
        bus.fwd_mem_we = mem_we; bus.fwd_mem_rd = mem_rd; bus.fwd_mem_data = mem_d;
    endtask

    // Monitor: every consumed instruction must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_issue", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_a", bus.out_a, e.a);
                chk("out_b", bus.out_b, e.b);
                chk("out_alu_sel", {29'd0, bus.out_alu_sel}, {29'd0, e.sel});
                chk("out_rd_idx", {27'd0, bus.out_rd_idx}, {27'd0, e.rd});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        issue(5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 3'b000, 5'd0);
        bus.in_valid = 1'b0;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_a", bus.out_a, 32'd0);
        chk("rst_out_b", bus.out_b, 32'd0);
        chk("rst_out_sel", {29'd0, bus.out_alu_sel}, 32'd0);
        chk("rst_out_rd", {27'd0, bus.out_rd_idx}, 32'd0);
        chk("rst_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Basic issue
        tick();
        issue(5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 3'b000, 5'd4);
        push(32'd5, 32'd7, 3'b000, 5'd4);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("basic_out_valid", {31'd0, bus.out_valid}, 32'd1);

        // Forward priority, back-to-back issues
        tick();
        issue(5'd3, 32'h11, 5'd5, 32'h22, 32'd0, 1'b0, 3'b001, 5'd6);
        set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        push(32'hAA, 32'h22, 3'b001, 5'd6);
        tick();
        issue(5'd0, 32'h33, 5'd0, 32'h44, 32'd0, 1'b0, 3'b010, 5'd7);
        set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
        push(32'h33, 32'h44, 3'b010, 5'd7);
        tick();
        issue(5'd8, 32'h55, 5'd7, 32'h66, 32'd0, 1'b0, 3'b111, 5'd9);
        set_fwd(1'b1, 5'd1, 32'hAA, 1'b1, 5'd7, 32'hCC);
        push(32'h55, 32'hCC, 3'b111, 5'd9);
        tick();
        bus.in_valid = 1'b0;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();

        // Hold snoop, stall counter, then consume with simultaneous accept
        bus.out_ready = 1'b0;
        issue(5'd8, 32'h100, 5'd9, 32'h200, 32'd0, 1'b0, 3'b010, 5'd10);
        push(32'h100, 32'h1234, 3'b010, 5'd10);
        tick();
        issue(5'd11, 32'h55, 5'd12, 32'h66, 32'd0, 1'b0, 3'b101, 5'd13);
        @(negedge clk);
        chk("hold_in_ready_c1", {31'd0, bus.in_ready}, 32'd0);
        tick();
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1234);
        @(negedge clk);
        chk("hold_in_ready_c2", {31'd0, bus.in_ready}, 32'd0);
        tick();
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("hold_in_ready_c3", {31'd0, bus.in_ready}, 32'd0);
        tick();
        bus.out_ready = 1'b1;
        push(32'h55, 32'h66, 3'b101, 5'd13);
        @(negedge clk);
        chk("hold_stall_cnt", {16'd0, bus.stall_cnt}, 32'd3);
        chk("hold_out_b", bus.out_b, 32'h1234);
        tick();
        bus.in_valid = 1'b0;
        tick();

        // Immediate protected from snooping
        bus.out_ready = 1'b0;
        issue(5'd0, 32'h1, 5'd9, 32'h200, 32'h10, 1'b1, 3'b000, 5'd14);
        push(32'h1, 32'h10, 3'b000, 5'd14);
        tick();
        bus.in_valid = 1'b0;
        tick();
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1234);
        tick();
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("imm_stall_cnt", {16'd0, bus.stall_cnt}, 32'd6);
        chk("imm_out_b", bus.out_b, 32'h10);
        tick();

        // Flush wins over accept
        issue(5'd1, 32'hDEAD, 5'd2, 32'hBEEF, 32'd0, 1'b0, 3'b000, 5'd15);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Reset in the middle of a hold
        tick();
        bus.out_ready = 1'b0;
        issue(5'd1, 32'h77, 5'd2, 32'h88, 32'd0, 1'b0, 3'b110, 5'd16);
        tick();
        bus.in_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("prerst_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("prerst_stall_cnt", {16'd0, bus.stall_cnt}, 32'd7);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_out_a", bus.out_a, 32'd0);
        chk("midrst_out_b", bus.out_b, 32'd0);
        chk("midrst_out_sel", {29'd0, bus.out_alu_sel}, 32'd0);
        chk("midrst_out_rd", {27'd0, bus.out_rd_idx}, 32'd0);
        chk("midrst_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);

        // Shift-amount masking (depends on build macro)
        tick();
        issue(5'd1, 32'h3, 5'd2, 32'h25, 32'd0, 1'b0, 3'b011, 5'd1);
        push(32'h3, MASK_ON ? 32'h5 : 32'h25, 3'b011, 5'd1);
        tick();
        issue(5'd1, 32'h4, 5'd2, 32'hFFFF_FFE3, 32'd0, 1'b0, 3'b100, 5'd2);
        push(32'h4, MASK_ON ? 32'h3 : 32'hFFFF_FFE3, 3'b100, 5'd2);
        tick();
        issue(5'd1, 32'h6, 5'd2, 32'h0, 32'h41, 1'b1, 3'b011, 5'd3);
        push(32'h6, MASK_ON ? 32'h1 : 32'h41, 3'b011, 5'd3);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-issue pipeline stage sitting directly upstream of the 32-bit ALU. It captures decoded operands from the decode stage through a valid/ready handshake. It resolves read-after-write hazards by forwarding from the EX and MEM results, selects register or immediate for operand B, and presents registered `a`, `b` and `alu_sel` to the ALU. While its output is stalled, it keeps the held operands coherent by snooping the forward buses.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `REGW`, 5, register index width
- `CNTW`, 16, stall counter width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  decode presents an instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_rs1_idx`, `in_rs2_idx`, `in_rd_idx`  in  REGW  source and destination indices
- `in_rs1_val`, `in_rs2_val`  in  XLEN  register-file read data
- `in_imm`  in  XLEN  sign-extended immediate
- `in_use_imm`  in  1  operand B is `in_imm`, not rs2
- `in_alu_sel`  in  3  ALU op code (000 ADD … 111 SLT)
- `flush`  in  1  discard held and incoming instruction
- `fwd_ex_we`, `fwd_ex_rd`, `fwd_ex_data`  in  1/REGW/XLEN  EX-stage result bus
- `fwd_mem_we`, `fwd_mem_rd`, `fwd_mem_data`  in  1/REGW/XLEN  MEM-stage result bus
- `out_valid`  out  1  registered instruction valid toward ALU
- `out_ready`  in  1  ALU stage consumes
- `out_a`, `out_b`  out  XLEN  ALU operands
- `out_alu_sel`  out  3  ALU op
- `out_rd_idx`  out  REGW  destination index
- `stall_cnt`  out  CNTW  saturating count of stalled cycles

## Operation
- `in_ready = !out_valid || out_ready` (combinational). Accept when `in_valid && in_ready`.
- Forward resolution, per source `idx`:
  - if `idx != 0 && fwd_ex_we && fwd_ex_rd == idx`, use `fwd_ex_data`;
  - else if `idx != 0 && fwd_mem_we && fwd_mem_rd == idx`, use `fwd_mem_data`;
  - else use the register-file value.
  - EX has priority over MEM. Index 0 is never forwarded.
- Operand B: `in_use_imm` ? `in_imm` : forwarded rs2. An immediate is never overwritten by snooping.
- On accept, register `a`, `b`, `alu_sel`, `rd_idx`, the source indices and the use_imm flag, and set `out_valid=1`.
- Hold (`out_valid && !out_ready`):
  - re-apply forward resolution to the held `a` (rs1) each cycle;
  - re-apply it to the held `b` if use_imm is 0;
  - other fields are unchanged.
- Consume without new accept: `out_valid` goes to 0. Simultaneous consume and accept: the new instruction loads with no bubble.
- `flush`: next cycle `out_valid=0`, and any accept in the same cycle is discarded. `flush` has priority over accept and hold. `in_ready` is unaffected by `flush`.
- `stall_cnt`: +1 each cycle with `out_valid && !out_ready`, saturating at all-ones. It is not cleared by `flush`.

## Timing
- Latency: accepted in cycle N, presented on `out_*` in cycle N+1.
- Throughput: one instruction per cycle when `out_ready=1`.
- Reset (`rst=1` at an edge): `out_valid`, `out_a`, `out_b`, `out_alu_sel`, `out_rd_idx`, `stall_cnt` and all internal state become 0. `rst` overrides `flush` and accept. Mid-transfer instructions are lost.
- Forward data is sampled at the same edge as capture or hold. A forward write coinciding with accept is seen in N+1.
- `out_*` fields are don't-care-stable only while `out_valid=1`. When `out_valid=0` they retain their last values.

## Configuration
- `ALU_ISSUE_SHAMT_MASK_EN` defined:
  - when the latched op is 011 (LSL) or 100 (LSR), `out_b` is presented as `{ {XLEN-5{1'b0}}, b[4:0] }`;
  - masking is applied at capture and after each hold update.
- Undefined: `out_b` is passed unmasked for all ops.

## Test plan
- Basic issue:
  - stimulus: reset, then `in_valid=1` with rs1_val=5, rs2_val=7, sel=000, `out_ready=1`;
  - required: next cycle `out_valid=1`, `out_a=5`, `out_b=7`, `out_alu_sel=000`.
- Forward priority:
  - stimulus: rs1_idx=3, EX writes rd=3 data=0xAA, MEM writes rd=3 data=0xBB;
  - required: `out_a=0xAA`. Repeat with idx 0: `out_a` = in_rs1_val.
- Hold snoop and stall counter:
  - stimulus: `out_ready=0` for 3 cycles, MEM writes rs2 idx with data 0x1234 in hold cycle 2, `in_use_imm=0`;
  - required: `out_b=0x1234`, `stall_cnt=3`, `in_ready=0` throughout the hold.
- Immediate protection:
  - stimulus: same as the hold-snoop scenario but `in_use_imm=1`, imm=0x10;
  - required: `out_b` stays 0x10.
- Flush vs accept:
  - stimulus: `flush=1` and accept in the same cycle;
  - required: next cycle `out_valid=0`. `rst` mid-hold zeroes all outputs.
- Shift masking:
  - stimulus: macro defined, sel=011, rs2_val=0x25;
  - required: `out_b=0x5`. With the macro undefined: `out_b=0x25`.
